// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared definitions for the sequential instruction prefetch buffer:
// datapath width, the NOP returned while stalled, default reset PC and
// the controller state encoding.
package fetch_prefetch_buffer_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] ARVI_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_STEP = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } pf_state_e;

    // Address of the next sequential instruction word; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
        return addr + WORD_STEP;
    endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_pf_fifo.sv
// Small circular FIFO holding prefetched instruction words.
// Flush empties it and takes priority over a push on the same edge.
module pf_fifo
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = XLEN
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping with flush ahead of push/pop.
    always_ff @(posedge i_clk) begin
        if (!i_rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetch buffer between instruction memory and
// the fetch stage. Streams PC, PC+4, ... into a FIFO ahead of demand and
// restarts at any non-sequential PC, discarding an in-flight stale word.
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_Addr,
    input  logic            i_Hold,
    output logic [XLEN-1:0] o_Data,
    output logic            o_Stall,
    output logic            o_DataReq,
    output logic [XLEN-1:0] o_MemAddr,
    input  logic [XLEN-1:0] i_DataBlock,
    input  logic            i_MemReady
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    pf_state_e       state;
    logic [XLEN-1:0] head_addr;
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] req_addr;
    logic            data_req;

    logic [XLEN-1:0] fifo_rdata;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

    logic            hit;
    logic            redirect;
    logic            pop;
    logic            push;
    logic [CW-1:0]   count_next;
    logic [XLEN-1:0] redirect_addr;

    pf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (push),
        .wdata (i_DataBlock),
        .pop   (pop),
        .flush (redirect),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Hit/redirect decode depends only on i_Addr and registered state so the
    // stall output never loops through the core's hold logic.
    always_comb begin
        redirect      = (i_Addr != head_addr);
        hit           = !fifo_empty && !redirect;
        pop           = hit && !i_Hold;
        push          = (state == ST_FETCH) && i_MemReady && !redirect;
        count_next    = fifo_count + CW'(push) - CW'(pop);
        redirect_addr = {i_Addr[XLEN-1:2], 2'b00};
    end

    assign o_Stall   = !hit;
    assign o_Data    = hit ? fifo_rdata : ARVI_NOP;
    assign o_DataReq = data_req;
    assign o_MemAddr = req_addr;

    // Address tracking and the request FSM with registered request outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            data_req   <= 1'b0;
            head_addr  <= PC_RESET;
            fetch_addr <= PC_RESET;
            req_addr   <= PC_RESET;
        end else begin
            if (redirect) begin
                head_addr  <= redirect_addr;
                fetch_addr <= redirect_addr;
            end else begin
                if (pop) begin
                    head_addr <= next_word(head_addr);
                end
                if (push) begin
                    fetch_addr <= next_word(fetch_addr);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (!redirect && !fifo_full) begin
                        req_addr <= fetch_addr;
                        data_req <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (redirect) begin
                        if (i_MemReady) begin
                            data_req <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end else if (i_MemReady) begin
                        if (count_next < DEPTH_C) begin
                            req_addr <= next_word(fetch_addr);
                        end else begin
                            data_req <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (i_MemReady) begin
                        data_req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    data_req <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Self-checking bench for fetch_prefetch_buffer: a queue-based model of the
// buffered instruction stream checked every cycle, plus directed scenarios
// with hand-computed expectations.
module tb_fetch_prefetch_buffer;
    import fetch_prefetch_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] PCR = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [31:0] i_Addr = '0;
    logic        i_Hold = 1'b0;
    logic [31:0] o_Data;
    logic        o_Stall;
    logic        o_DataReq;
    logic [31:0] o_MemAddr;
    logic [31:0] i_DataBlock = '0;
    logic        i_MemReady = 1'b0;

    int total = 0;
    int bad = 0;
    logic check_en = 1'b0;
    int lat = 1;
    int resp_cnt = 0;
    logic [31:0] served[$];
    logic [31:0] delivered[$];

    // model: buffered words, head address, next fetch address, in-flight request
    logic [31:0] q[$];
    logic [31:0] m_head = PCR;
    logic [31:0] m_next = PCR;
    logic [31:0] m_req_addr = PCR;
    logic        m_req_on = 1'b0;
    logic        m_req_stale = 1'b0;

    fetch_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .PC_RESET (PCR)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_Addr      (i_Addr),
        .i_Hold      (i_Hold),
        .o_Data      (o_Data),
        .o_Stall     (o_Stall),
        .o_DataReq   (o_DataReq),
        .o_MemAddr   (o_MemAddr),
        .i_DataBlock (i_DataBlock),
        .i_MemReady  (i_MemReady)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] addr, input logic hold);
        i_rst  = rst;
        i_Addr = addr;
        i_Hold = hold;
        #1;
    endtask

    task automatic compareModel();
        logic exp_hit;
        exp_hit = (q.size() > 0) && (i_Addr == m_head);
        checkOutput("stall", 32'(o_Stall), 32'(!exp_hit));
        checkOutput("data", o_Data, exp_hit ? q[0] : ARVI_NOP);
        checkOutput("data_req", 32'(o_DataReq), 32'(m_req_on));
        if (m_req_on) checkOutput("mem_addr", o_MemAddr, m_req_addr);
        if (!o_Stall && !i_Hold && i_rst) delivered.push_back(o_Data);
    endtask

    task automatic modelEdge();
        int sz;
        logic redir;
        logic fin;
        logic was_on;
        if (!i_rst) begin
            q.delete();
            m_head = PCR;
            m_next = PCR;
            m_req_addr = PCR;
            m_req_on = 1'b0;
            m_req_stale = 1'b0;
            return;
        end
        sz = q.size();
        redir = (i_Addr != m_head);
        fin = m_req_on && i_MemReady;
        was_on = m_req_on;
        if (sz > 0 && !redir && !i_Hold) begin
            void'(q.pop_front());
            m_head = m_head + 32'd4;
        end
        if (fin && !m_req_stale && !redir) begin
            q.push_back(memf(m_req_addr));
            m_next = m_next + 32'd4;
        end
        if (redir) begin
            q.delete();
            m_head = {i_Addr[31:2], 2'b00};
            m_next = m_head;
        end
        if (was_on) begin
            if (fin) begin
                if (!m_req_stale && !redir && q.size() < DEPTH) begin
                    m_req_addr = m_next;
                end else begin
                    m_req_on = 1'b0;
                    m_req_stale = 1'b0;
                end
            end else if (redir) begin
                m_req_stale = 1'b1;
            end
        end else if (!redir && sz < DEPTH) begin
            m_req_on = 1'b1;
            m_req_addr = m_next;
        end
    endtask

    task automatic responder();
        i_MemReady = 1'b0;
        i_DataBlock = '0;
        if (o_DataReq) begin
            resp_cnt++;
            if (resp_cnt > lat) begin
                i_MemReady = 1'b1;
                i_DataBlock = memf(o_MemAddr);
                served.push_back(o_MemAddr);
                resp_cnt = 0;
            end
        end else begin
            resp_cnt = 0;
        end
    endtask

    task automatic runCycle();
        @(negedge i_clk);
        if (check_en) compareModel();
        @(posedge i_clk);
        modelEdge();
        if (!i_rst) check_en = 1'b1;
        #1;
        responder();
    endtask

    task automatic doReset();
        applyStimulus(1'b0, PCR, 1'b0);
        runCycle();
        runCycle();
        served.delete();
        delivered.delete();
    endtask

    task automatic runFollow(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, m_head, 1'b0);
            runCycle();
        end
    endtask

    task automatic runHold(input int n, input logic [31:0] addr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, addr, 1'b1);
            runCycle();
        end
    endtask

    initial begin
        logic found;

        // reset values and sequential streaming, latency 1
        lat = 1;
        doReset();
        #1;
        checkOutput("rst_data_req", 32'(o_DataReq), 32'd0);
        checkOutput("rst_mem_addr", o_MemAddr, 32'h0);
        checkOutput("rst_stall", 32'(o_Stall), 32'd1);
        checkOutput("rst_data", o_Data, 32'h0000_0013);
        applyStimulus(1'b1, 32'h0, 1'b0);
        runCycle();
        #1;
        checkOutput("first_req", 32'(o_DataReq), 32'd1);
        checkOutput("first_addr", o_MemAddr, 32'h0);
        runFollow(30);
        if (delivered.size() >= 3) begin
            checkOutput("stream_w0", delivered[0], 32'hC0DE_0000);
            checkOutput("stream_w1", delivered[1], 32'hC0DE_0004);
            checkOutput("stream_w2", delivered[2], 32'hC0DE_0008);
        end else begin
            checkOutput("stream_count", delivered.size(), 32'd3);
        end

        // fill to full under hold, then a one-cycle release
        doReset();
        runHold(16, 32'h0);
        #1;
        checkOutput("full_req_cnt", served.size(), 32'd4);
        if (served.size() == 4) checkOutput("full_last_addr", served[3], 32'hC);
        checkOutput("full_no_req", 32'(o_DataReq), 32'd0);
        applyStimulus(1'b1, 32'h0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 32'h4, 1'b1);
        runCycle();
        #1;
        checkOutput("refill_req", 32'(o_DataReq), 32'd1);
        checkOutput("refill_addr", o_MemAddr, 32'h10);

        // redirect to 0x100 while 0x8 is in flight
        lat = 3;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (o_DataReq && o_MemAddr == 32'h8) found = 1'b1;
            else begin
                applyStimulus(1'b1, 32'h0, 1'b1);
                runCycle();
            end
        end
        if (!found) checkOutput("wait_req8", 32'd0, 32'd1);
        served.delete();
        delivered.delete();
        applyStimulus(1'b1, 32'h100, 1'b1);
        runCycle();
        #1;
        checkOutput("discard_req", 32'(o_DataReq), 32'd1);
        checkOutput("discard_addr", o_MemAddr, 32'h8);
        runFollow(30);
        if (served.size() >= 2) begin
            checkOutput("stale_served", served[0], 32'h8);
            checkOutput("after_redirect", served[1], 32'h100);
        end else checkOutput("redirect_served", served.size(), 32'd2);
        if (delivered.size() >= 1) checkOutput("redirect_word", delivered[0], 32'hC0DE_0100);
        else checkOutput("redirect_deliver", 32'd0, 32'd1);

        // redirect on the same edge as i_MemReady
        lat = 2;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (i_MemReady) found = 1'b1;
            else begin
                applyStimulus(1'b1, 32'h0, 1'b1);
                runCycle();
            end
        end
        if (!found) checkOutput("wait_ready", 32'd0, 32'd1);
        applyStimulus(1'b1, 32'h200, 1'b1);
        runCycle();
        #1;
        checkOutput("coinc_idle", 32'(o_DataReq), 32'd0);
        checkOutput("coinc_stall", 32'(o_Stall), 32'd1);
        applyStimulus(1'b1, 32'h200, 1'b1);
        runCycle();
        #1;
        checkOutput("coinc_req", 32'(o_DataReq), 32'd1);
        checkOutput("coinc_addr", o_MemAddr, 32'h200);

        // push and pop on the same edge at count 2
        lat = 1;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (i_MemReady && served.size() == 3) found = 1'b1;
            else begin
                applyStimulus(1'b1, 32'h0, 1'b1);
                runCycle();
            end
        end
        if (!found) checkOutput("wait_third", 32'd0, 32'd1);
        applyStimulus(1'b1, 32'h0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 32'h4, 1'b1);
        #1;
        checkOutput("pp_stall", 32'(o_Stall), 32'd0);
        checkOutput("pp_head", o_Data, 32'hC0DE_0004);
        runHold(20, 32'h4);
        #1;
        checkOutput("pp_served", served.size(), 32'd5);
        if (served.size() == 5) checkOutput("pp_last", served[4], 32'h10);
        checkOutput("pp_full", 32'(o_DataReq), 32'd0);

        // reset in the middle of a request, then a late i_MemReady
        lat = 4;
        doReset();
        applyStimulus(1'b1, 32'h0, 1'b1);
        runCycle();
        #1;
        checkOutput("mid_req", 32'(o_DataReq), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        runCycle();
        applyStimulus(1'b1, 32'h0, 1'b1);
        i_MemReady = 1'b1;
        i_DataBlock = 32'hDEAD_BEEF;
        resp_cnt = 0;
        #1;
        checkOutput("mid_rst_req", 32'(o_DataReq), 32'd0);
        checkOutput("mid_rst_addr", o_MemAddr, 32'h0);
        checkOutput("mid_rst_stall", 32'(o_Stall), 32'd1);
        checkOutput("mid_rst_data", o_Data, 32'h0000_0013);
        runCycle();
        #1;
        checkOutput("late_ignored", 32'(o_Stall), 32'd1);
        checkOutput("late_req", 32'(o_DataReq), 32'd1);
        delivered.delete();
        runFollow(30);
        if (delivered.size() >= 1) checkOutput("late_word", delivered[0], 32'hC0DE_0000);
        else checkOutput("late_deliver", 32'd0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
